// File: rtl/ram_2port.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Read-during-write to the same address returns the old word.
module ram_2port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              sclk,
    input  logic              srst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic              rden,
    output logic [DATA_W-1:0] q,
    output logic              q_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Zero at power-up; reset never touches the array.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            if (wren) begin
                mem[wraddress] <= data;
            end
            if (rden) begin
                q <= mem[rdaddress];
            end
            q_valid <= rden;
        end
    end

endmodule

// File: tb/tb_ram_2port.sv
// Randomized and directed checks of ram_2port against an array model.
// Model applies each edge as read-then-write, so collisions see old data.
module tb_ram_2port;

    logic       sclk;
    logic       srst_n;
    logic [7:0] data;
    logic [7:0] wraddress;
    logic       wren;
    logic [7:0] rdaddress;
    logic       rden;
    logic [7:0] q;
    logic       q_valid;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [256];
    logic [7:0] exp_q;
    logic       exp_v;

    ram_2port #(.DATA_W(8), .ADDR_W(8)) dut (
        .sclk      (sclk),
        .srst_n    (srst_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q),
        .q_valid   (q_valid)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        if (srst_n) begin
            if (rden) begin
                exp_q = mem_m[rdaddress];
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            if (wren) mem_m[wraddress] = data;
        end else begin
            exp_q = 8'h00;
            exp_v = 1'b0;
        end
        #1;
        check("q", {24'd0, q}, {24'd0, exp_q});
        check("q_valid", {31'd0, q_valid}, {31'd0, exp_v});
    endtask

    task automatic op(input logic we, input logic [7:0] wa,
                      input logic [7:0] wd, input logic re,
                      input logic [7:0] ra);
        wren      = we;
        wraddress = wa;
        data      = wd;
        rden      = re;
        rdaddress = ra;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        exp_q     = 8'h00;
        exp_v     = 1'b0;
        srst_n    = 1'b1;
        wren      = 1'b0;
        rden      = 1'b0;
        data      = 8'h00;
        wraddress = 8'h00;
        rdaddress = 8'h00;
        #2 srst_n = 1'b0;
        #1;
        check("rst_q", {24'd0, q}, 32'h0);
        check("rst_qv", {31'd0, q_valid}, 32'h0);

        // Writes and reads attempted while reset is held are ignored.
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 8'h42, 8'($urandom_range(1, 255)), 1'b1,
               8'($urandom));
        end
        srst_n = 1'b1;
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h42);
        check("rst_nowrite", {24'd0, q}, 32'h0);

        // Basic write then consecutive reads.
        op(1'b1, 8'h01, 8'h01, 1'b0, 8'h00);
        op(1'b1, 8'h02, 8'h00, 1'b0, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
        check("basic0", {24'd0, q}, 32'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h01);
        check("basic1", {24'd0, q}, 32'h01);
        check("basic1_v", {31'd0, q_valid}, 32'h1);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h02);
        check("basic2", {24'd0, q}, 32'h00);
        op(1'b0, 8'h00, 8'h00, 1'b0, 8'h01);
        check("hold_q", {24'd0, q}, 32'h00);
        check("hold_v", {31'd0, q_valid}, 32'h0);

        // Same-address collision returns the old word.
        op(1'b1, 8'h05, 8'h11, 1'b0, 8'h00);
        op(1'b1, 8'h05, 8'hA5, 1'b1, 8'h05);
        check("rdw_old", {24'd0, q}, 32'h11);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h05);
        check("rdw_new", {24'd0, q}, 32'hA5);

        // Independent ports.
        op(1'b1, 8'h20, 8'h77, 1'b0, 8'h00);
        op(1'b1, 8'h10, 8'h3C, 1'b1, 8'h20);
        check("indep_rd", {24'd0, q}, 32'h77);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h10);
        check("indep_wr", {24'd0, q}, 32'h3C);

        // Full sweep.
        for (int i = 0; i < 256; i++) begin
            op(1'b1, 8'(i), ~8'(i), 1'b0, 8'h00);
        end
        for (int i = 0; i < 256; i++) begin
            op(1'b0, 8'h00, 8'h00, 1'b1, 8'(i));
            check("sweep", {24'd0, q}, {24'd0, ~8'(i)});
        end

        // Top and bottom addresses back to back.
        op(1'b1, 8'hFF, 8'h5A, 1'b0, 8'h00);
        op(1'b1, 8'h00, 8'hC3, 1'b0, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF);
        check("wrap_ff", {24'd0, q}, 32'h5A);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
        check("wrap_00", {24'd0, q}, 32'hC3);

        // Asynchronous reset pulse between edges while streaming reads.
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h03);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h04);
        #2 srst_n = 1'b0;
        #1;
        check("async_q", {24'd0, q}, 32'h0);
        check("async_v", {31'd0, q_valid}, 32'h0);
        exp_q = 8'h00;
        exp_v = 1'b0;
        #1 srst_n = 1'b1;
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h03);
        check("post_rst", {24'd0, q}, {24'd0, ~8'h03});
        check("post_rst_v", {31'd0, q_valid}, 32'h1);

        // Random traffic, biased toward collisions on a small window.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] wa;
            logic [7:0] ra;
            wa = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7))
                                             : 8'($urandom);
            ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7))
                                             : 8'($urandom);
            op(1'($urandom), wa, 8'($urandom), 1'($urandom), ra);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
